// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fpu_pkg
// Brief    : Shared binary32 constants, divider state encoding and operand
//            classification used by the floating-point divider.
// Revision : 1.0
// ============================================================================
package fpu_pkg;

    localparam int          EXP_BIAS   = 127;
    localparam logic [31:0] QNAN       = 32'h7FC0_0000;
    localparam int          FDIV_ITERS = 27;
    localparam int          ITER_W     = 5;

    typedef enum logic [1:0] {
        FDIV_IDLE  = 2'd0,
        FDIV_DIV   = 2'd1,
        FDIV_ROUND = 2'd2
    } fdiv_state_t;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
    } fclass_t;

    // Exponent 0 is classed as zero so denormal inputs are flushed.
    function automatic fclass_t classify(input logic [31:0] x);
        fclass_t c;
        c.nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        c.inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        c.zero = (x[30:23] == 8'h00);
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fdiv_round.sv
`default_nettype none
// ============================================================================
// Module   : fdiv_round
// Brief    : Combinational normalise / round-to-nearest-even / special-case
//            resolution stage for the binary32 divider.
// Revision : 1.0
// ============================================================================
module fdiv_round
    import fpu_pkg::*;
(
    input  logic [26:0] i_q,
    input  logic [23:0] i_rem,
    input  logic [7:0]  i_es,
    input  logic [7:0]  i_et,
    input  logic        i_s_sign,
    input  logic        i_t_sign,
    input  logic [21:0] i_s_pay,
    input  logic [21:0] i_t_pay,
    input  fclass_t     i_s_cls,
    input  fclass_t     i_t_cls,
    output logic [31:0] o_result,
    output logic        o_overflow,
    output logic        o_underflow,
    output logic        o_div_by_zero
);

    localparam logic signed [9:0] c_bias_hi = 10'(EXP_BIAS);
    localparam logic signed [9:0] c_bias_lo = 10'(EXP_BIAS - 1);

    logic               w_norm;
    logic [22:0]        w_frac_pre;
    logic               w_guard;
    logic               w_round;
    logic               w_sticky;
    logic               w_inc;
    logic               w_carry;
    logic [22:0]        w_frac;
    logic signed [9:0]  w_exp_pre;
    logic signed [9:0]  w_exp;
    logic               w_ovf;
    logic               w_unf;
    logic               w_sign;

    // The hidden bit is always set here, so only the 23 fraction bits are
    // rounded; a carry out of them means the mantissa wrapped to 2.0.
    assign w_norm     = i_q[26];
    assign w_frac_pre = w_norm ? i_q[25:3] : i_q[24:2];
    assign w_guard    = w_norm ? i_q[2] : i_q[1];
    assign w_round    = w_norm ? i_q[1] : i_q[0];
    assign w_sticky   = (w_norm & i_q[0]) | (i_rem != 24'd0);
    assign w_inc      = w_guard & (w_round | w_sticky | w_frac_pre[0]);

    assign {w_carry, w_frac} = {1'b0, w_frac_pre} + {23'd0, w_inc};

    assign w_exp_pre = $signed({2'b00, i_es}) - $signed({2'b00, i_et})
                     + (w_norm ? c_bias_hi : c_bias_lo);
    assign w_exp     = w_exp_pre + $signed({9'd0, w_carry});
    assign w_ovf     = (w_exp >= 10'sd255);
    assign w_unf     = (w_exp <= 10'sd0);
    assign w_sign    = i_s_sign ^ i_t_sign;

    always_comb begin
        o_result      = {w_sign, w_exp[7:0], w_frac};
        o_overflow    = 1'b0;
        o_underflow   = 1'b0;
        o_div_by_zero = 1'b0;
        if (i_s_cls.nan) begin
            o_result = {i_s_sign, 8'hFF, 1'b1, i_s_pay};
        end else if (i_t_cls.nan) begin
            o_result = {i_t_sign, 8'hFF, 1'b1, i_t_pay};
        end else if ((i_s_cls.inf && i_t_cls.inf) || (i_s_cls.zero && i_t_cls.zero)) begin
            o_result = QNAN;
        end else if (i_s_cls.inf) begin
            o_result = {w_sign, 8'hFF, 23'd0};
        end else if (i_t_cls.inf) begin
            o_result = {w_sign, 31'd0};
        end else if (i_t_cls.zero) begin
            o_result      = {w_sign, 8'hFF, 23'd0};
            o_div_by_zero = 1'b1;
        end else if (i_s_cls.zero) begin
            o_result = {w_sign, 31'd0};
        end else if (w_ovf) begin
            o_result   = {w_sign, 8'hFF, 23'd0};
            o_overflow = 1'b1;
        end else if (w_unf) begin
            o_result    = {w_sign, 31'd0};
            o_underflow = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fdiv.sv
`default_nettype none
// ============================================================================
// Module   : fdiv
// Brief    : Multi-cycle IEEE-754 binary32 divider; restoring radix-2 core,
//            one quotient bit per cycle, fixed 28-cycle latency.
// Revision : 1.0
// ============================================================================
module fdiv
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [31:0] s,
    input  logic [31:0] t,
    output logic        ready,
    output logic [31:0] d,
    output logic        done,
    output logic        overflow,
    output logic        underflow,
    output logic        div_by_zero
);

    fdiv_state_t       r_state;
    logic [ITER_W-1:0] r_iter;
    logic [26:0]       r_q;
    logic [24:0]       r_rem;
    logic [23:0]       r_mt;
    logic [7:0]        r_es;
    logic [7:0]        r_et;
    logic              r_s_sign;
    logic              r_t_sign;
    logic [21:0]       r_s_pay;
    logic [21:0]       r_t_pay;
    fclass_t           r_s_cls;
    fclass_t           r_t_cls;

    logic [24:0]       w_diff;
    logic              w_bit;
    logic [24:0]       w_keep;
    logic              w_last;
    logic [31:0]       w_result;
    logic              w_ovf;
    logic              w_unf;
    logic              w_dbz;

    // Partial remainder stays below 2*mt, so 25 bits suffice.
    assign w_diff = r_rem - {1'b0, r_mt};
    assign w_bit  = (r_rem >= {1'b0, r_mt});
    assign w_keep = w_bit ? w_diff : r_rem;
    assign w_last = (r_iter == ITER_W'(FDIV_ITERS - 1));

    fdiv_round u_round (
        .i_q           (r_q),
        .i_rem         (r_rem[23:0]),
        .i_es          (r_es),
        .i_et          (r_et),
        .i_s_sign      (r_s_sign),
        .i_t_sign      (r_t_sign),
        .i_s_pay       (r_s_pay),
        .i_t_pay       (r_t_pay),
        .i_s_cls       (r_s_cls),
        .i_t_cls       (r_t_cls),
        .o_result      (w_result),
        .o_overflow    (w_ovf),
        .o_underflow   (w_unf),
        .o_div_by_zero (w_dbz)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= FDIV_IDLE;
            ready       <= 1'b1;
            done        <= 1'b0;
            d           <= 32'd0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            div_by_zero <= 1'b0;
            r_iter      <= '0;
            r_q         <= '0;
            r_rem       <= '0;
            r_mt        <= '0;
            r_es        <= '0;
            r_et        <= '0;
            r_s_sign    <= 1'b0;
            r_t_sign    <= 1'b0;
            r_s_pay     <= '0;
            r_t_pay     <= '0;
            r_s_cls     <= '0;
            r_t_cls     <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                FDIV_IDLE: begin
                    if (start && ready) begin
                        r_state  <= FDIV_DIV;
                        ready    <= 1'b0;
                        r_iter   <= '0;
                        r_q      <= '0;
                        r_rem    <= {2'b01, s[22:0]};
                        r_mt     <= {1'b1, t[22:0]};
                        r_es     <= s[30:23];
                        r_et     <= t[30:23];
                        r_s_sign <= s[31];
                        r_t_sign <= t[31];
                        r_s_pay  <= s[21:0];
                        r_t_pay  <= t[21:0];
                        r_s_cls  <= classify(s);
                        r_t_cls  <= classify(t);
                    end
                end
                FDIV_DIV: begin
                    r_q    <= {r_q[25:0], w_bit};
                    r_iter <= r_iter + ITER_W'(1);
                    // The final remainder is kept unshifted for the sticky bit.
                    if (w_last) begin
                        r_rem   <= w_keep;
                        r_state <= FDIV_ROUND;
                    end else begin
                        r_rem <= w_keep << 1;
                    end
                end
                FDIV_ROUND: begin
                    d           <= w_result;
                    overflow    <= w_ovf;
                    underflow   <= w_unf;
                    div_by_zero <= w_dbz;
                    done        <= 1'b1;
                    ready       <= 1'b1;
                    r_state     <= FDIV_IDLE;
                end
                default: begin
                    r_state <= FDIV_IDLE;
                    ready   <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fdiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_fdiv
// Brief    : Self-checking bench for fdiv: directed vectors, random operands
//            against an arithmetic reference, and handshake/reset sequences.
// Revision : 1.0
// ============================================================================
module tb_fdiv;

    logic        clk   = 1'b0;
    logic        rstn  = 1'b0;
    logic        start = 1'b0;
    logic [31:0] s     = 32'd0;
    logic [31:0] t     = 32'd0;
    logic        ready;
    logic [31:0] d;
    logic        done;
    logic        overflow;
    logic        underflow;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic        ov;
        logic        un;
        logic        dz;
    } vec_t;

    vec_t        vecs[$];
    logic [34:0] res;
    int          lat;
    int          n_done;
    int          first_lat;
    logic [31:0] got_d;
    logic [31:0] ra;
    logic [31:0] rb;

    fdiv dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .s           (s),
        .t           (t),
        .ready       (ready),
        .d           (d),
        .done        (done),
        .overflow    (overflow),
        .underflow   (underflow),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: exact integer quotient of the scaled mantissas, then
    // IEEE round-to-nearest-even with flush-to-zero and saturation.
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b);
        int          ea = int'(a[30:23]);
        int          eb = int'(b[30:23]);
        bit          a_nan  = (ea == 255) && (a[22:0] != 0);
        bit          b_nan  = (eb == 255) && (b[22:0] != 0);
        bit          a_inf  = (ea == 255) && (a[22:0] == 0);
        bit          b_inf  = (eb == 255) && (b[22:0] == 0);
        bit          a_zero = (ea == 0);
        bit          b_zero = (eb == 0);
        logic        sg = a[31] ^ b[31];
        logic [63:0] num;
        logic [63:0] den;
        logic [63:0] q;
        logic [63:0] rem;
        logic [63:0] mant;
        int          e;
        bit          g;
        bit          r;
        bit          st;
        if (a_nan) return {a[31], 8'hFF, 1'b1, a[21:0], 3'b000};
        if (b_nan) return {b[31], 8'hFF, 1'b1, b[21:0], 3'b000};
        if ((a_inf && b_inf) || (a_zero && b_zero)) return {32'h7FC00000, 3'b000};
        if (a_inf)  return {sg, 8'hFF, 23'd0, 3'b000};
        if (b_inf)  return {sg, 31'd0, 3'b000};
        if (b_zero) return {sg, 8'hFF, 23'd0, 3'b001};
        if (a_zero) return {sg, 31'd0, 3'b000};
        num = {40'd1, a[22:0]} << 26;
        den = {40'd1, b[22:0]};
        q   = num / den;
        rem = num % den;
        if (q >= (64'd1 << 26)) begin
            mant = q >> 3; g = q[2]; r = q[1]; st = q[0] || (rem != 0);
            e = ea - eb + 127;
        end else begin
            mant = q >> 2; g = q[1]; r = q[0]; st = (rem != 0);
            e = ea - eb + 126;
        end
        if (g && (r || st || mant[0])) mant = mant + 1;
        if (mant == (64'd1 << 24)) begin
            mant = 64'd1 << 23;
            e = e + 1;
        end
        if (e >= 255) return {sg, 8'hFF, 23'd0, 3'b100};
        if (e <= 0)   return {sg, 31'd0, 3'b010};
        return {sg, 8'(e), mant[22:0], 3'b000};
    endfunction

    function automatic void add(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] q, input logic [2:0] f);
        vecs.push_back(vec_t'{a, b, q, f[2], f[1], f[0]});
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [34:0] r_out, output int l_out);
        int w = 0;
        @(negedge clk);
        while (!ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!ready) check("ready_timeout", 64'(ready), 64'd1);
        s = a; t = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        l_out = 0;
        while (!done && l_out < 60) begin
            @(posedge clk); #1;
            l_out++;
        end
        r_out = {d, overflow, underflow, div_by_zero};
    endtask

    initial begin
        add(32'h40C00000, 32'h40000000, 32'h40400000, 3'b000);
        add(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 3'b000);
        add(32'h3F800000, 32'h00000000, 32'h7F800000, 3'b001);
        add(32'h00000000, 32'h00000000, 32'h7FC00000, 3'b000);
        add(32'h7F000000, 32'h00800000, 32'h7F800000, 3'b100);
        add(32'h00800000, 32'h40000000, 32'h00000000, 3'b010);
        add(32'hFF812345, 32'h3F800000, 32'hFFC12345, 3'b000);
        add(32'h3F800000, 32'h7F800001, 32'h7FC00001, 3'b000);
        add(32'h7F800002, 32'hFFC00000, 32'h7FC00002, 3'b000);
        add(32'h7F800000, 32'hFF800000, 32'h7FC00000, 3'b000);
        add(32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000);
        add(32'h7F800000, 32'h00000000, 32'h7F800000, 3'b000);
        add(32'h3F800000, 32'h7F800000, 32'h00000000, 3'b000);
        add(32'hBF800000, 32'h7F800000, 32'h80000000, 3'b000);
        add(32'h3F800000, 32'h80000000, 32'hFF800000, 3'b001);
        add(32'h00000000, 32'hC0A00000, 32'h80000000, 3'b000);
        add(32'h00000001, 32'h3F800000, 32'h00000000, 3'b000);
        add(32'h00800000, 32'h3F800000, 32'h00800000, 3'b000);
        add(32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 3'b000);
        add(32'h7F7FFFFF, 32'h3F7FFFFF, 32'h7F800000, 3'b100);
        add(32'hC0C00000, 32'h40000000, 32'hC0400000, 3'b000);
        add(32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000);

        // Reset state
        #12;
        check("reset_outputs", {58'd0, ready, done, overflow, underflow, div_by_zero, 1'b0} | 64'(d),
              {58'd0, 1'b1, 5'b00000});
        check("reset_d", 64'(d), 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Directed vectors
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, res, lat);
            check($sformatf("vec%0d_d", i), 64'(res[34:3]), 64'(vecs[i].q));
            check($sformatf("vec%0d_flags", i), 64'(res[2:0]), {61'd0, vecs[i].ov, vecs[i].un, vecs[i].dz});
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd28);
        end

        // Random operands against the reference model
        for (int i = 0; i < 300; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) != 0) ra[30:23] = 8'($urandom_range(1, 254));
            if ($urandom_range(0, 3) != 0) rb[30:23] = 8'($urandom_range(1, 254));
            run_op(ra, rb, res, lat);
            check($sformatf("rand%0d %h/%h", i, ra, rb), {22'd0, res, 7'(lat)}, {22'd0, model(ra, rb), 7'd28});
        end

        // start pulsed during DIV must be ignored
        @(negedge clk);
        s = 32'h40C00000; t = 32'h40000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; s = 32'hDEADBEEF; t = 32'h12345678;
        check("busy_ready_low", 64'(ready), 64'd0);
        n_done = 0; first_lat = 0; got_d = 32'd0;
        for (int c = 1; c <= 70; c++) begin
            @(posedge clk); #1;
            start = (c == 10);
            s = (c == 10) ? 32'h3F800000 : 32'hDEADBEEF;
            t = (c == 10) ? 32'h40400000 : 32'h12345678;
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    first_lat = c;
                    got_d = d;
                end
            end
        end
        start = 1'b0;
        check("ignore_latency", 64'(first_lat), 64'd28);
        check("ignore_d", 64'(got_d), 64'h40400000);
        check("ignore_done_count", 64'(n_done), 64'd1);

        // Back-to-back: new start accepted in the done cycle
        @(negedge clk);
        s = 32'h40C00000; t = 32'h40000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b_first_latency", 64'(lat), 64'd28);
        check("b2b_first_d", 64'(d), 64'h40400000);
        check("b2b_ready_in_done", 64'(ready), 64'd1);
        s = 32'h3F800000; t = 32'h40400000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b_second_latency", 64'(lat), 64'd28);
        check("b2b_second_d", 64'(d), 64'h3EAAAAAB);

        // Reset asserted at DIV iteration 10 aborts the operation
        @(negedge clk);
        s = 32'h40C00000; t = 32'h40000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rstn = 1'b0;
        #2;
        check("abort_reset_flags", {59'd0, ready, done, overflow, underflow, div_by_zero}, 64'h10);
        check("abort_reset_d", 64'(d), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check("abort_no_done", 64'(n_done), 64'd0);
        check("abort_idle_outputs", {27'd0, ready, done, overflow, underflow, div_by_zero, d},
              {27'd0, 5'b10000, 32'd0});
        run_op(32'h40C00000, 32'h40000000, res, lat);
        check("after_reset_d", 64'(res[34:3]), 64'h40400000);
        check("after_reset_latency", 64'(lat), 64'd28);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
